// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file debug dump path: state encodings and
// default widths, also used by the host bridge.
package regfile_dump_reader_pkg;

   localparam int DBG_DATA_W = 8;
   localparam int DBG_SEL_W  = 4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READ   = 3'd1;
   localparam logic [2:0] ST_EMIT_A = 3'd2;
   localparam logic [2:0] ST_EMIT_B = 3'd3;
   localparam logic [2:0] ST_FIN    = 3'd4;

endpackage

// File: rtl/regfile_dump_reader_dump_pair_buf.sv
// Two-entry capture register holding one register pair, with an A/B output select.
module dump_pair_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              sel_b,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] buf_a_reg;
   logic [DATA_W-1:0] buf_b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_a_reg <= '0;
         buf_b_reg <= '0;
      end else if (load) begin
         buf_a_reg <= in_a;
         buf_b_reg <= in_b;
      end
   end

   assign data = sel_b ? buf_b_reg : buf_a_reg;

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: reads the register file two registers at a time and streams
// each value as an indexed byte over a valid/ready interface.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int DATA_W   = DBG_DATA_W,
   parameter int SEL_W    = DBG_SEL_W,
   parameter int NUM_REGS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [SEL_W-1:0]  rd_sel_a,
   output logic [SEL_W-1:0]  rd_sel_b,
   input  logic [DATA_W-1:0] rd_data_a,
   input  logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [SEL_W:0] LAST_END = (SEL_W+1)'(NUM_REGS);

   logic [2:0]        state_reg, state_next;
   logic [SEL_W-1:0]  idx_reg, idx_next;
   logic [SEL_W-1:0]  sel_a_reg, sel_a_next;
   logic [SEL_W-1:0]  sel_b_reg, sel_b_next;
   logic [DATA_W-1:0] pair_data;
   logic              accept;
   logic              last_pair;

   assign accept    = out_valid && out_ready;
   // Widened so that the final pair's idx+2 equals NUM_REGS instead of wrapping to 0.
   assign last_pair = (({1'b0, idx_reg} + (SEL_W+1)'(2)) == LAST_END);

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      sel_a_next = sel_a_reg;
      sel_b_next = sel_b_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               state_next = ST_READ;
               idx_next   = '0;
               sel_a_next = '0;
               sel_b_next = SEL_W'(1);
            end
         end
         ST_READ:   state_next = ST_EMIT_A;
         ST_EMIT_A: if (accept) state_next = ST_EMIT_B;
         ST_EMIT_B: begin
            if (accept) begin
               if (last_pair) begin
                  state_next = ST_FIN;
               end else begin
                  state_next = ST_READ;
                  idx_next   = idx_reg + SEL_W'(2);
                  sel_a_next = idx_reg + SEL_W'(2);
                  sel_b_next = idx_reg + SEL_W'(3);
               end
            end
         end
         ST_FIN: begin
            state_next = ST_IDLE;
            idx_next   = '0;
            sel_a_next = '0;
            sel_b_next = SEL_W'(1);
         end
         default: begin
            state_next = ST_IDLE;
            idx_next   = '0;
            sel_a_next = '0;
            sel_b_next = SEL_W'(1);
         end
      endcase
      if (abort && (state_reg != ST_IDLE)) begin
         state_next = ST_IDLE;
         idx_next   = '0;
         sel_a_next = '0;
         sel_b_next = SEL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
         sel_a_reg <= '0;
         sel_b_reg <= SEL_W'(1);
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         sel_a_reg <= sel_a_next;
         sel_b_reg <= sel_b_next;
      end
   end

   dump_pair_buf #(
      .DATA_W(DATA_W)
   ) u_pair_buf (
      .clk   (clk),
      .rst   (rst),
      .load  (state_reg == ST_READ),
      .in_a  (rd_data_a),
      .in_b  (rd_data_b),
      .sel_b (state_reg == ST_EMIT_B),
      .data  (pair_data)
   );

   assign rd_sel_a  = sel_a_reg;
   assign rd_sel_b  = sel_b_reg;
   assign out_valid = (state_reg == ST_EMIT_A) || (state_reg == ST_EMIT_B);
   assign out_data  = out_valid ? pair_data : '0;
   assign out_index = (state_reg == ST_EMIT_B) ? (idx_reg + SEL_W'(1)) :
                      (state_reg == ST_EMIT_A) ? idx_reg : '0;
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a small behavioural register file.
module tb_regfile_dump_reader;

   localparam int DATA_W   = 8;
   localparam int SEL_W    = 4;
   localparam int NUM_REGS = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [SEL_W-1:0]  rd_sel_a, rd_sel_b;
   logic [DATA_W-1:0] rd_data_a, rd_data_b;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_index;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              busy, done;

   logic              preload = 1'b1;
   logic              write_en = 1'b0;
   logic [SEL_W-1:0]  write_addr = '0;
   logic [DATA_W-1:0] write_data = '0;
   logic [DATA_W-1:0] regs [NUM_REGS];

   typedef struct packed {
      logic [SEL_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int done_count = 0;

   always #5 clk = ~clk;

   regfile_dump_reader #(
      .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_REGS(NUM_REGS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   assign rd_data_a = regs[rd_sel_a];
   assign rd_data_b = regs[rd_sel_b];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preload) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= DATA_W'(8'hA0 + i);
      end else if (write_en) begin
         regs[write_addr] <= write_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Sink monitor: accepted bytes are scored, held bytes must stay frozen.
   logic              hold_prev = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic [SEL_W-1:0]  prev_index = '0;
   always @(negedge clk) begin
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            check_eq("hold_valid", out_valid, 1'b1);
            check_eq("hold_data", out_data, prev_data);
            check_eq("hold_index", out_index, prev_index);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("byte t=%0d index=%0d data=%02h (exp index=%0d data=%02h)",
                        cyc, out_index, out_data, e.idx, e.data);
               check_eq("sb_index", out_index, e.idx);
               check_eq("sb_data", out_data, e.data);
            end
         end
         if (done) done_count <= done_count + 1;
         hold_prev  <= out_valid && !out_ready && !abort;
         prev_data  <= out_data;
         prev_index <= out_index;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_dump(input logic [DATA_W-1:0] r5_val, output int s_cyc);
      for (int i = 0; i < NUM_REGS; i++) begin
         exp_t e;
         e.idx  = SEL_W'(i);
         e.data = (i == 5) ? r5_val : DATA_W'(8'hA0 + i);
         exp_q.push_back(e);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, output int d_cyc, output int gaps);
      bit seen;
      seen  = 1'b0;
      gaps  = 0;
      d_cyc = -1;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen  = 1'b1;
            d_cyc = cyc;
         end else if (!busy) begin
            gaps++;
         end
      end
      check_eq({tag, "_done_seen"}, seen, 1'b1);
   endtask

   task automatic wait_emit(input string tag, input int index);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (out_valid && out_index == SEL_W'(index)) seen = 1'b1;
      end
      check_eq({tag, "_emit_seen"}, seen, 1'b1);
   endtask

   task automatic write_reg(input int addr, input logic [DATA_W-1:0] val);
      write_en   = 1'b1;
      write_addr = SEL_W'(addr);
      write_data = val;
      tick();
      write_en   = 1'b0;
   endtask

   initial begin
      int s_cyc, d_cyc, gaps;
      bit seen;

      repeat (3) tick();
      preload = 1'b0;
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_sel_a", rd_sel_a, 0);
      check_eq("rst_sel_b", rd_sel_b, 1);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_index", out_index, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Full dump with ready held high: latency, throughput, single done.
      start_dump(8'hA5, s_cyc);
      check_eq("lat_read_valid", out_valid, 1'b0);
      check_eq("lat_read_busy", busy, 1'b1);
      check_eq("lat_read_sel_a", rd_sel_a, 0);
      check_eq("lat_read_sel_b", rd_sel_b, 1);
      tick();
      check_eq("lat_first_valid", out_valid, 1'b1);
      check_eq("lat_first_index", out_index, 0);
      check_eq("lat_first_data", out_data, 8'hA0);
      wait_done("full", d_cyc, gaps);
      // FIN is cycle N+25, i.e. 24 edges after the edge that sampled start.
      check_eq("full_done_latency", d_cyc - s_cyc, 24);
      check_eq("full_busy_gaps", gaps, 0);
      tick();
      check_eq("full_done_width", done, 1'b0);
      check_eq("full_idle_busy", busy, 1'b0);
      check_eq("full_sb_empty", exp_q.size(), 0);
      check_eq("full_done_count", done_count, 1);

      // Backpressure on index 3.
      start_dump(8'hA5, s_cyc);
      wait_emit("bp", 3);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("bp_index", out_index, 3);
         check_eq("bp_data", out_data, 8'hA3);
      end
      out_ready = 1'b1;
      wait_done("bp", d_cyc, gaps);
      tick();
      check_eq("bp_sb_empty", exp_q.size(), 0);
      check_eq("bp_done_count", done_count, 2);

      // Abort during EMIT_B of pair (6,7).
      start_dump(8'hA5, s_cyc);
      wait_emit("abort", 7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_valid", out_valid, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_done", done, 1'b0);
      exp_q.delete();
      repeat (30) tick();
      check_eq("abort_no_done", done_count, 2);
      start_dump(8'hA5, s_cyc);
      tick();
      check_eq("restart_index", out_index, 0);
      wait_done("restart", d_cyc, gaps);
      tick();
      check_eq("restart_sb_empty", exp_q.size(), 0);
      check_eq("restart_done_count", done_count, 3);

      // Start while busy at idx=4 is ignored.
      start_dump(8'hA5, s_cyc);
      wait_emit("busy_start", 4);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("busy_start", d_cyc, gaps);
      repeat (40) tick();
      check_eq("busy_start_idle", busy, 1'b0);
      check_eq("busy_start_sb_empty", exp_q.size(), 0);
      check_eq("busy_start_done_count", done_count, 4);

      // Asynchronous reset during READ of pair (10,11).
      start_dump(8'hA5, s_cyc);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (busy && !out_valid && rd_sel_a == SEL_W'(10)) seen = 1'b1;
      end
      check_eq("rst_mid_read_seen", seen, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_valid", out_valid, 1'b0);
      check_eq("rst_mid_busy", busy, 1'b0);
      check_eq("rst_mid_done", done, 1'b0);
      check_eq("rst_mid_sel_a", rd_sel_a, 0);
      check_eq("rst_mid_sel_b", rd_sel_b, 1);
      check_eq("rst_mid_data", out_data, 0);
      check_eq("rst_mid_index", out_index, 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      repeat (30) tick();
      check_eq("rst_mid_no_done", done_count, 4);

      // Write r5 after its pair was sampled: old value streamed.
      start_dump(8'hA5, s_cyc);
      wait_emit("wr_after", 4);
      write_reg(5, 8'h55);
      wait_done("wr_after", d_cyc, gaps);
      tick();
      check_eq("wr_after_sb_empty", exp_q.size(), 0);
      write_reg(5, 8'hA5);
      tick();

      // Write r5 before its pair is sampled: new value streamed.
      start_dump(8'h55, s_cyc);
      write_reg(5, 8'h55);
      wait_done("wr_before", d_cyc, gaps);
      tick();
      check_eq("wr_before_sb_empty", exp_q.size(), 0);
      check_eq("final_done_count", done_count, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
